wide_enum_seq: RTL and testbench

Sequencing controller for a 160-bit wide-encoded enum register. Two requesters each propose a new 160-bit enum value. A round-robin arbiter picks one, and the controller checks that the value is a legal enum member before loading it. After a load, the register is held stable for a programmable number of cycles. The block sits in front of any logic that consumes the wide enum state and guarantees that only legal encodings ever appear on its output.

---
 rtl/wide_enum_seq_pkg.sv | 26 ++
 rtl/wide_enum_seq_rr_arb2.sv | 25 ++
 rtl/wide_enum_seq.sv | 138 +++++++++++++
 tb/tb_wide_enum_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/wide_enum_seq_pkg.sv
// Shared types for the wide enum sequencer: the legal 160-bit encodings, FSM states
// and the membership test used to gate loads.
package wide_enum_seq_pkg;

  localparam int unsigned HOLD_CYC_MAX = 255;
  localparam int unsigned HOLD_W       = $clog2(HOLD_CYC_MAX + 1);

  typedef enum logic [159:0] {
    E01    = 160'h1,
    E02    = 160'h2,
    EMID   = 160'h1_0000_0000_0000_0000,
    ELARGE = 160'h1234_4567_abcd_1234_4567_abcd
  } my_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Full-width compare: a value that only matches in its low bits is still illegal.
  function automatic bit is_member(input logic [159:0] v);
    return (v == E01) || (v == E02) || (v == EMID) || (v == ELARGE);
  endfunction

endpackage

// File: rtl/wide_enum_seq_rr_arb2.sv
// Two-input round-robin arbiter. The pointer names the preferred requester and
// flips to the other one whenever a winner is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_win
);

  logic r_ptr;

  always_comb begin
    // NOTE: default first so every path assigns o_win and no latch is inferred.
    o_win = i_req;
    if (i_req == 2'b11) o_win = r_ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n)                       r_ptr <= 1'b0;
    else if (i_advance && (|i_req))   r_ptr <= o_win[0];
  end

endmodule

// File: rtl/wide_enum_seq.sv
// Wide enum sequencer: arbitrates two 160-bit load requests, rejects illegal
// encodings, and holds each accepted value for HOLD_CYC cycles.
// Optional trace of loads/rejects: define WIDE_ENUM_SEQ_TRACE_EN.
module wide_enum_seq
  import wide_enum_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYC = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [159:0]  val0,
  input  logic          req1,
  input  logic [159:0]  val1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          err,
  output my_t           e,
  output logic          busy,
  output logic [31:0]   load_cnt
);

  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYC);

  state_t              r_state;
  state_t              w_next_state;
  logic [1:0]          w_req;
  logic [1:0]          w_win;
  logic                w_sample;
  logic                w_accept;
  logic                w_reject;
  logic                w_busy;
  logic [1:0]          r_win;
  logic [159:0]        r_val;
  logic [HOLD_W-1:0]   r_hold_cnt;
  my_t                 r_e;
  logic [31:0]         r_load_cnt;
  logic                r_gnt0;
  logic                r_gnt1;
  logic                r_err;

  assign w_req = {req1, req0};

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (w_req),
    .i_advance (w_sample),
    .o_win     (w_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_sample     = 1'b0;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (|w_req) begin
          w_sample     = 1'b1;
          w_next_state = GRANT;
        end
      end
      GRANT: begin
        if (is_member(r_val)) begin
          w_accept     = 1'b1;
          w_next_state = HOLD;
        end else begin
          w_reject     = 1'b1;
          w_next_state = IDLE;
        end
      end
      HOLD: begin
        if (r_hold_cnt == HOLD_W'(1)) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Value and winner are captured at sampling; later changes on val0/val1 are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win      <= 2'b00;
      r_val      <= '0;
      r_hold_cnt <= '0;
      r_e        <= E01;
      r_load_cnt <= '0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_err  <= 1'b0;
      if (w_sample) begin
        r_win <= w_win;
        r_val <= w_win[1] ? val1 : val0;
      end
      if (w_accept || w_reject) begin
        r_gnt0 <= r_win[0];
        r_gnt1 <= r_win[1];
      end
      if (w_reject) r_err <= 1'b1;
      if (w_accept) begin
        r_e        <= my_t'(r_val);
        r_load_cnt <= r_load_cnt + 32'd1;
        r_hold_cnt <= HOLD_INIT;
      end else if (r_state == HOLD) begin
        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
      end
    end
  end

`ifdef WIDE_ENUM_SEQ_TRACE_EN
  my_t w_trace_e;
  assign w_trace_e = my_t'(r_val);

  always_ff @(posedge clk) begin
    if (rst_n && w_accept) $display("wide_enum_seq load %s", w_trace_e.name());
    if (rst_n && w_reject) $display("ILLEGAL %h", r_val);
  end
`endif

  assign gnt0     = r_gnt0;
  assign gnt1     = r_gnt1;
  assign err      = r_err;
  assign e        = r_e;
  assign busy     = w_busy;
  assign load_cnt = r_load_cnt;

endmodule

// File: tb/tb_wide_enum_seq.sv
// Self-checking bench for wide_enum_seq: a cycle-by-cycle vector table plus
// sequences for alternation, counter wrap and reset during HOLD.
module tb_wide_enum_seq;

  localparam int unsigned HOLD = 3;

  localparam logic [159:0] L_E01    = 160'h1;
  localparam logic [159:0] L_E02    = 160'h2;
  localparam logic [159:0] L_EMID   = 160'h1_0000_0000_0000_0000;
  localparam logic [159:0] L_ELARGE = 160'h1234_4567_abcd_1234_4567_abcd;
  localparam logic [159:0] L_BAD3   = 160'h3;
  localparam logic [159:0] L_BADMID = 160'h1_0000_0000_0000_0001;
  localparam logic [159:0] L_BADTOP = {1'b1, 159'h0} | 160'h1234_4567_abcd_1234_4567_abcd;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1;
  logic [159:0]  val0, val1;
  logic          gnt0, gnt1, err, busy;
  logic [159:0]  e_raw;
  logic [31:0]   load_cnt;

  int n_checks = 0;
  int n_err    = 0;

  wide_enum_seq #(.HOLD_CYC(HOLD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .val0     (val0),
    .req1     (req1),
    .val1     (val1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .err      (err),
    .e        (e_raw),
    .busy     (busy),
    .load_cnt (load_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         r0;
    logic [159:0] v0;
    logic         r1;
    logic [159:0] v1;
    logic         g0;
    logic         g1;
    logic         er;
    logic         bz;
    logic [159:0] ee;
    logic [31:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r0, input logic [159:0] v0, input logic r1, input logic [159:0] v1,
                     input logic g0, input logic g1, input logic er, input logic bz,
                     input logic [159:0] ee, input logic [31:0] cnt);
    vec_t v;
    v.r0 = r0; v.v0 = v0; v.r1 = r1; v.v1 = v1;
    v.g0 = g0; v.g1 = g1; v.er = er; v.bz = bz; v.ee = ee; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check_idle(input string tag, input logic [159:0] exp_e, input logic [31:0] exp_cnt);
    check({tag, " gnt0"}, 160'(gnt0), 160'(1'b0));
    check({tag, " gnt1"}, 160'(gnt1), 160'(1'b0));
    check({tag, " err"}, 160'(err), 160'(1'b0));
    check({tag, " busy"}, 160'(busy), 160'(1'b0));
    check({tag, " e"}, e_raw, exp_e);
    check({tag, " load_cnt"}, 160'(load_cnt), 160'(exp_cnt));
  endtask

  initial begin
    int grant_cyc[$];
    int grant_idx[$];
    int cyc;
    bit seen;

    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; val0 = '0; val1 = '0;

    // Reset and idle.
    tick(); tick();
    check_idle("in_reset", L_E01, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle($sformatf("idle%0d", i), L_E01, 32'd0);
    end

    // Cycle-by-cycle table; each row's outputs are observed after the edge it drives.
    // Single req0 load of ELARGE; val0 change after sampling must be ignored.
    add(1, L_ELARGE, 0, '0,       0, 0, 0, 1, L_E01,    1'd0 ? 32'd0 : 32'd0);
    add(1, L_E02,    0, '0,       1, 0, 0, 1, L_ELARGE, 32'd1);
    add(1, L_E02,    0, '0,       0, 0, 0, 1, L_ELARGE, 32'd1);
    add(0, '0,       0, '0,       0, 0, 0, 1, L_ELARGE, 32'd1);
    add(0, '0,       0, '0,       0, 0, 0, 0, L_ELARGE, 32'd1);
    // Illegal value 3 from req1, then req0 sampled two edges later.
    add(0, '0,       1, L_BAD3,   0, 0, 0, 1, L_ELARGE, 32'd1);
    add(0, '0,       1, L_BAD3,   0, 1, 1, 0, L_ELARGE, 32'd1);
    add(1, L_E02,    0, '0,       0, 0, 0, 1, L_ELARGE, 32'd1);
    add(1, L_E02,    0, '0,       1, 0, 0, 1, L_E02,    32'd2);
    add(0, '0,       0, '0,       0, 0, 0, 1, L_E02,    32'd2);
    add(0, '0,       0, '0,       0, 0, 0, 1, L_E02,    32'd2);
    add(0, '0,       0, '0,       0, 0, 0, 0, L_E02,    32'd2);
    // Pointer now prefers req1, but a lone req0 still wins.
    add(1, L_EMID,   0, '0,       0, 0, 0, 1, L_E02,    32'd2);
    add(1, L_EMID,   0, '0,       1, 0, 0, 1, L_EMID,   32'd3);
    add(0, '0,       0, '0,       0, 0, 0, 1, L_EMID,   32'd3);
    add(0, '0,       0, '0,       0, 0, 0, 1, L_EMID,   32'd3);
    add(0, '0,       0, '0,       0, 0, 0, 0, L_EMID,   32'd3);
    // Both request with pointer at 1: req1 wins, req0 stays pending and follows.
    add(1, L_E02,    1, L_ELARGE, 0, 0, 0, 1, L_EMID,   32'd3);
    add(1, L_E02,    1, L_ELARGE, 0, 1, 0, 1, L_ELARGE, 32'd4);
    add(1, L_E02,    0, '0,       0, 0, 0, 1, L_ELARGE, 32'd4);
    add(1, L_E02,    0, '0,       0, 0, 0, 1, L_ELARGE, 32'd4);
    add(1, L_E02,    0, '0,       0, 0, 0, 0, L_ELARGE, 32'd4);
    add(1, L_E02,    0, '0,       0, 0, 0, 1, L_ELARGE, 32'd4);
    add(1, L_E02,    0, '0,       1, 0, 0, 1, L_E02,    32'd5);
    add(0, '0,       0, '0,       0, 0, 0, 1, L_E02,    32'd5);
    add(0, '0,       0, '0,       0, 0, 0, 1, L_E02,    32'd5);
    add(0, '0,       0, '0,       0, 0, 0, 0, L_E02,    32'd5);
    // Near-miss encodings: low bits of EMID+1, and ELARGE with bit 159 set.
    add(1, L_BADMID, 0, '0,       0, 0, 0, 1, L_E02,    32'd5);
    add(0, '0,       0, '0,       1, 0, 1, 0, L_E02,    32'd5);
    add(0, '0,       1, L_BADTOP, 0, 0, 0, 1, L_E02,    32'd5);
    add(0, '0,       0, '0,       0, 1, 1, 0, L_E02,    32'd5);
    add(0, '0,       0, '0,       0, 0, 0, 0, L_E02,    32'd5);

    foreach (vecs[i]) begin
      req0 = vecs[i].r0; val0 = vecs[i].v0;
      req1 = vecs[i].r1; val1 = vecs[i].v1;
      tick();
      check($sformatf("vec%0d gnt0", i), 160'(gnt0), 160'(vecs[i].g0));
      check($sformatf("vec%0d gnt1", i), 160'(gnt1), 160'(vecs[i].g1));
      check($sformatf("vec%0d err", i), 160'(err), 160'(vecs[i].er));
      check($sformatf("vec%0d busy", i), 160'(busy), 160'(vecs[i].bz));
      check($sformatf("vec%0d e", i), e_raw, vecs[i].ee);
      check($sformatf("vec%0d load_cnt", i), 160'(load_cnt), 160'(vecs[i].cnt));
    end

    // Fresh reset, then both requesters held: grants alternate 0,1,0,1 at HOLD+2 spacing.
    rst_n = 1'b0;
    tick();
    check("rst2 ptr", 160'(dut.u_arb.r_ptr), 160'(1'b0));
    rst_n = 1'b1;
    req0 = 1'b1; val0 = L_E02; req1 = 1'b1; val1 = L_EMID;
    for (int c = 1; c <= 40 && grant_cyc.size() < 4; c++) begin
      tick();
      if (gnt0 && gnt1) check("alt both gnt", 160'(2'b11), 160'(2'b01));
      if (gnt0 || gnt1) begin
        grant_cyc.push_back(c);
        grant_idx.push_back(gnt1 ? 1 : 0);
        check($sformatf("alt%0d e", grant_cyc.size() - 1), e_raw, gnt1 ? L_EMID : L_E02);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("alt grant count", 160'(grant_cyc.size()), 160'(4));
    foreach (grant_cyc[k]) begin
      check($sformatf("alt%0d cycle", k), 160'(grant_cyc[k]), 160'(2 + k * (HOLD + 2)));
      check($sformatf("alt%0d winner", k), 160'(grant_idx[k]), 160'(k % 2));
    end
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      seen = !busy;
    end
    check("alt drained", 160'(seen), 160'(1'b1));
    check("alt load_cnt", 160'(load_cnt), 160'(32'd4));

    // load_cnt wrap from all-ones.
    force dut.r_load_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_load_cnt;
    check("wrap preset", 160'(load_cnt), 160'(32'hFFFF_FFFF));
    req0 = 1'b1; val0 = L_E01;
    tick();
    tick();
    req0 = 1'b0;
    check("wrap gnt0", 160'(gnt0), 160'(1'b1));
    check("wrap load_cnt", 160'(load_cnt), 160'(32'd0));
    check("wrap e", e_raw, L_E01);
    for (int c = 0; c < HOLD; c++) tick();
    check("wrap idle busy", 160'(busy), 160'(1'b0));

    // Reset during HOLD; pending req0 is granted normally after release.
    req0 = 1'b1; val0 = L_ELARGE;
    tick();
    tick();
    check("mid gnt0", 160'(gnt0), 160'(1'b1));
    check("mid ptr before", 160'(dut.u_arb.r_ptr), 160'(1'b1));
    tick();
    check("mid busy", 160'(busy), 160'(1'b1));
    check("mid e", e_raw, L_ELARGE);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst e", e_raw, L_E01);
    check("mid rst busy", 160'(busy), 160'(1'b0));
    check("mid rst load_cnt", 160'(load_cnt), 160'(32'd0));
    check("mid rst ptr", 160'(dut.u_arb.r_ptr), 160'(1'b0));
    tick();
    check("mid rst gnt0", 160'(gnt0), 160'(1'b0));
    val0 = L_E02;
    rst_n = 1'b1;
    cyc = 0;
    seen = 1'b0;
    for (int c = 1; c <= 6 && !seen; c++) begin
      tick();
      if (gnt0) begin
        seen = 1'b1;
        cyc = c;
      end
    end
    req0 = 1'b0;
    check("post rst gnt seen", 160'(seen), 160'(1'b1));
    check("post rst gnt cycle", 160'(cyc), 160'(2));
    check("post rst e", e_raw, L_E02);
    check("post rst load_cnt", 160'(load_cnt), 160'(32'd1));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
